// File: rtl/pa_in_capture.sv
// rtl/pa_in_capture.sv - async parallel-port sampler feeding the datapath PI bus with load_fifo pulses
// Optional feature macro: PA_IN_TESTPAT_EN (adds test_mode and the internal data pattern).
module pa_in_capture #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pa_strobe,
  input  logic [7:0]       pa_data,
  input  logic             fifo_full,
  input  logic             clr_ovf,
`ifdef PA_IN_TESTPAT_EN
  input  logic             test_mode,
`endif
  output logic [7:0]       pi_data,
  output logic             load_fifo,
  output logic             overflow,
  output logic [CNT_W-1:0] sample_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    LOAD    = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   strobe_d;
  logic                   strobe_rise;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          buf_full, buf_empty;
  logic          push_req, push, pop, drop;
  logic [7:0]    push_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_sync <= '0;
      strobe_d    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
    end else begin
      strobe_sync  <= {strobe_sync[SYNC_STAGES-2:0], pa_strobe};
      strobe_d     <= strobe_sync[SYNC_STAGES-1];
      data_sync[0] <= pa_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign strobe_rise = strobe_sync[SYNC_STAGES-1] & ~strobe_d;

  assign buf_full  = (occ == (AW+1)'(DEPTH));
  assign buf_empty = (occ == '0);
  assign pop       = (state == LOAD);
  assign push_req  = strobe_rise & en;
  // A pop in the same cycle frees the head slot, so a full buffer can still accept.
  assign push      = push_req & (~buf_full | pop);
  assign drop      = push_req & buf_full & ~pop;

`ifdef PA_IN_TESTPAT_EN
  logic [1:0] pat_idx;
  logic [7:0] pat_byte;

  always_comb begin
    pat_byte = 8'hFF;
    case (pat_idx)
      2'd0: pat_byte = 8'hFF;
      2'd1: pat_byte = 8'hF0;
      2'd2: pat_byte = 8'hCC;
      2'd3: pat_byte = 8'hAA;
      default: pat_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pat_idx <= 2'd0;
    else if (push && test_mode) pat_idx <= pat_idx + 2'd1;
  end

  assign push_data = test_mode ? pat_byte : data_sync[SYNC_STAGES-1];
`else
  assign push_data = data_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        sample_count <= sample_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (clr_ovf)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pi_data <= 8'h00;
    end else begin
      state <= next_state;
      if (state == IDLE && !buf_empty) pi_data <= mem[rd_ptr];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!buf_empty) next_state = PRESENT;
      PRESENT: if (!fifo_full) next_state = LOAD;
      LOAD:    next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decoded from the state register so an async reset drops it immediately.
  assign load_fifo = (state == LOAD);

endmodule

// File: tb/tb_pa_in_capture.sv
// tb/tb_pa_in_capture.sv - randomized self-checking bench for pa_in_capture against a queue model
module tb_pa_in_capture;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n, en, pa_strobe, fifo_full, clr_ovf;
  logic [7:0]       pa_data;
`ifdef PA_IN_TESTPAT_EN
  logic             test_mode;
`endif
  logic [7:0]       pi_data;
  logic             load_fifo, overflow;
  logic [CNT_W-1:0] sample_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  int         exp_cnt;
  bit         exp_ovf;
  int         held;

  pa_in_capture #(.DEPTH(DEPTH), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .pa_strobe(pa_strobe), .pa_data(pa_data),
    .fifo_full(fifo_full), .clr_ovf(clr_ovf),
`ifdef PA_IN_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .pi_data(pi_data), .load_fifo(load_fifo), .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) if (reset_n && load_fifo) begin
    got.push_back(pi_data);
    got_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Behavioural rule: accepted if enabled and either draining or fewer than DEPTH held.
  task automatic model_push(input logic [7:0] d);
    if (en) begin
      if (!fifo_full || held < DEPTH) begin
        exp_q.push_back(d);
        exp_cnt++;
        if (fifo_full) held++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    @(negedge clock);
    pa_data = d; pa_strobe = 1'b1;
    tick(4);
    pa_strobe = 1'b0;
    tick(4);
    model_push(d);
  endtask

  task automatic release_and_drain();
    fifo_full = 1'b0; held = 0;
    tick(4 * DEPTH + 12);
  endtask

  task automatic model_clear();
    got.delete(); got_cyc.delete(); exp_q.delete();
    exp_cnt = 0; exp_ovf = 1'b0; held = 0;
  endtask

  task automatic test_reset();
    int waited;
    reset_n = 1'b0;
    tick(2);
    total++; if ({pi_data, load_fifo, overflow} !== 10'h0 || sample_count !== '0) begin
      bad++; $display("FAIL reset_state: pi=%h ld=%b ovf=%b cnt=%0d req all 0", pi_data, load_fifo, overflow, sample_count);
    end
    reset_n = 1'b1;
    tick(2);
    @(negedge clock);
    pa_data = 8'h3C; pa_strobe = 1'b1;
    waited = 0;
    while (!load_fifo && waited < 20) begin tick(1); waited++; end
    total++; if (load_fifo !== 1'b1) begin
      bad++; $display("FAIL reset_wait_load: load_fifo=%b req 1 within 20 cycles", load_fifo);
    end
    pa_strobe = 1'b0;
    reset_n = 1'b0;
    #1;
    total++; if (load_fifo !== 1'b0 || pi_data !== 8'h00 || overflow !== 1'b0 || sample_count !== '0) begin
      bad++; $display("FAIL reset_mid_load: ld=%b pi=%h ovf=%b cnt=%0d req 0", load_fifo, pi_data, overflow, sample_count);
    end
    tick(2);
    reset_n = 1'b1;
    tick(2);
    model_clear();
  endtask

  task automatic test_single();
    logic [7:0] pi_at2;
    logic       ld_at2, ld_at3, ld_at4;
    @(negedge clock);
    pa_data = 8'h5A; pa_strobe = 1'b1;
    tick(4); pi_at2 = pi_data; ld_at2 = load_fifo;
    tick(1); ld_at3 = load_fifo;
    tick(1); ld_at4 = load_fifo;
    pa_strobe = 1'b0;
    tick(6);
    exp_q.push_back(8'h5A); exp_cnt++;
    total++; if (pi_at2 !== 8'h5A || ld_at2 !== 1'b0) begin
      bad++; $display("FAIL single_pi_n2: pi=%h ld=%b req pi=5a ld=0", pi_at2, ld_at2);
    end
    total++; if (ld_at3 !== 1'b1 || ld_at4 !== 1'b0) begin
      bad++; $display("FAIL single_pulse: ld@N+3=%b ld@N+4=%b req 1,0", ld_at3, ld_at4);
    end
    total++; if (got.size() != 1 || sample_count !== CNT_W'(exp_cnt)) begin
      bad++; $display("FAIL single_count: pulses=%0d cnt=%0d req 1 and %0d", got.size(), sample_count, exp_cnt);
    end
    model_clear();
  endtask

  task automatic test_backpressure();
    int base_cnt;
    base_cnt = sample_count;
    fifo_full = 1'b1;
    strobe(8'h11); strobe(8'h22); strobe(8'h33);
    tick(6);
    total++; if (got.size() != 0) begin
      bad++; $display("FAIL bp_blocked: pulses=%0d req 0", got.size());
    end
    release_and_drain();
    total++; if (got.size() != 3) begin
      bad++; $display("FAIL bp_pulses: got %0d req 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got[i] !== exp_q[i]) begin
          bad++; $display("FAIL bp_order[%0d]: got %h req %h", i, got[i], exp_q[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++; if (got_cyc[i] - got_cyc[i-1] != 4) begin
          bad++; $display("FAIL bp_spacing[%0d]: got %0d clocks req 4", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    total++; if (int'(sample_count) != base_cnt + exp_cnt) begin
      bad++; $display("FAIL bp_count: got %0d req %0d", sample_count, base_cnt + exp_cnt);
    end
    model_clear();
  endtask

  task automatic test_overflow_random();
    int base_cnt, k;
    for (int r = 0; r < 5; r++) begin
      base_cnt = sample_count;
      k = (r == 0) ? DEPTH + 1 : int'($urandom_range(1, 2 * DEPTH));
      fifo_full = 1'b1;
      for (int j = 0; j < k; j++) strobe(8'($urandom));
      total++; if (overflow !== exp_ovf) begin
        bad++; $display("FAIL ovf_flag[%0d] k=%0d: got %b req %b", r, k, overflow, exp_ovf);
      end
      total++; if (int'(sample_count) != base_cnt + exp_cnt) begin
        bad++; $display("FAIL ovf_count[%0d] k=%0d: got %0d req %0d", r, k, sample_count, base_cnt + exp_cnt);
      end
      @(negedge clock); clr_ovf = 1'b1;
      @(negedge clock); clr_ovf = 1'b0;
      total++; if (overflow !== 1'b0) begin
        bad++; $display("FAIL ovf_clear[%0d]: got %b req 0", r, overflow);
      end
      release_and_drain();
      total++; if (got.size() != exp_q.size()) begin
        bad++; $display("FAIL ovf_drain_len[%0d]: got %0d req %0d", r, got.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          total++; if (got[i] !== exp_q[i]) begin
            bad++; $display("FAIL ovf_drain[%0d][%0d]: got %h req %h", r, i, got[i], exp_q[i]);
          end
        end
      end
      model_clear();
    end
  endtask

  task automatic test_en_random();
    int base_cnt;
    base_cnt = sample_count;
    en = 1'b0;
    for (int j = 0; j < 3; j++) strobe(8'($urandom));
    tick(4);
    total++; if (int'(sample_count) != base_cnt || overflow !== 1'b0 || got.size() != 0) begin
      bad++; $display("FAIL en_off: cnt=%0d ovf=%b pulses=%0d req %0d,0,0", sample_count, overflow, got.size(), base_cnt);
    end
    for (int j = 0; j < 12; j++) begin
      en = 1'($urandom);
      strobe(8'($urandom));
    end
    en = 1'b1;
    tick(10);
    total++; if (int'(sample_count) != base_cnt + exp_cnt || got.size() != exp_q.size()) begin
      bad++; $display("FAIL en_random: cnt=%0d pulses=%0d req %0d,%0d", sample_count, got.size(), base_cnt + exp_cnt, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got[i] !== exp_q[i]) begin
          bad++; $display("FAIL en_random_data[%0d]: got %h req %h", i, got[i], exp_q[i]);
        end
      end
    end
    model_clear();
  endtask

  task automatic test_push_pop_full();
    int base_cnt;
    logic [7:0] d;
    base_cnt = sample_count;
    fifo_full = 1'b1;
    for (int j = 0; j < DEPTH; j++) strobe(8'($urandom));
    d = 8'($urandom);
    @(negedge clock);
    pa_data = d; pa_strobe = 1'b1;
    @(negedge clock);
    fifo_full = 1'b0; held = 0;
    tick(3);
    pa_strobe = 1'b0;
    exp_q.push_back(d); exp_cnt++;
    tick(4 * DEPTH + 16);
    total++; if (overflow !== 1'b0 || int'(sample_count) != base_cnt + exp_cnt) begin
      bad++; $display("FAIL full_push_pop: ovf=%b cnt=%0d req 0,%0d", overflow, sample_count, base_cnt + exp_cnt);
    end
    total++; if (got.size() != exp_q.size()) begin
      bad++; $display("FAIL full_push_pop_len: got %0d req %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got[i] !== exp_q[i]) begin
          bad++; $display("FAIL full_push_pop_data[%0d]: got %h req %h", i, got[i], exp_q[i]);
        end
      end
    end
    model_clear();
  endtask

`ifdef PA_IN_TESTPAT_EN
  task automatic test_testpat();
    logic [7:0] pat [4];
    pat[0] = 8'hFF; pat[1] = 8'hF0; pat[2] = 8'hCC; pat[3] = 8'hAA;
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(2);
    model_clear();
    test_mode = 1'b1;
    for (int j = 0; j < 5; j++) strobe(8'($urandom));
    tick(6);
    test_mode = 1'b0;
    total++; if (got.size() != 5) begin
      bad++; $display("FAIL testpat_len: got %0d req 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (got[i] !== pat[i % 4]) begin
          bad++; $display("FAIL testpat[%0d]: got %h req %h", i, got[i], pat[i % 4]);
        end
      end
    end
    model_clear();
  endtask
`endif

  initial begin
    reset_n = 1'b0; en = 1'b1; pa_strobe = 1'b0; pa_data = 8'h00;
    fifo_full = 1'b0; clr_ovf = 1'b0;
`ifdef PA_IN_TESTPAT_EN
    test_mode = 1'b0;
`endif
    model_clear();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow_random();
    test_en_random();
    test_push_pop_full();
`ifdef PA_IN_TESTPAT_EN
    test_testpat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
